// File: rtl/fma_line_packer.sv
// Compacts valid FMA lane results into memory lines and queues finished lines for write-back.
// Optional statistics counters are enabled by defining FMA_LINE_PACKER_STATS_EN.
module fma_line_packer #(
  parameter int FMA_COUNT      = 2,
  parameter int WORD_WIDTH     = 16,
  parameter int WORDS_PER_LINE = 6,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [WORD_WIDTH*FMA_COUNT-1:0]    fma_out,
  input  logic [FMA_COUNT-1:0]               fma_valid_out,
  input  logic                               flush_in,
  output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] line_out,
  output logic [WORDS_PER_LINE-1:0]          line_mask_out,
  output logic                               line_valid_out,
  input  logic                               line_ready_in,
`ifdef FMA_LINE_PACKER_STATS_EN
  output logic [15:0]                        lines_pushed_out,
  output logic [15:0]                        lines_dropped_out,
`endif
  output logic                               overflow_out
);

  localparam int WPL = WORDS_PER_LINE;
  localparam int LW  = WORD_WIDTH * WPL;
  localparam int PW  = $clog2(2 * WPL);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic {FILLING, FLUSH_PENDING} state_t;

  state_t                state_reg;
  logic [PW-1:0]         p_reg;
  logic [WORD_WIDTH-1:0] part_reg [WPL];

  logic [WORD_WIDTH-1:0] ext [2*WPL];
  logic [WORD_WIDTH-1:0] part_next [WPL];
  logic [PW-1:0]         total;
  logic [PW-1:0]         p_next;
  logic                  spill;
  logic                  flush_eff;
  logic                  push_req;
  logic [LW-1:0]         push_line;
  logic [WPL-1:0]        push_mask;
  state_t                state_next;

  // Words beyond p in part_reg are always zero, so ext doubles as the zero-padded flush line.
  always_comb begin
    for (int i = 0; i < WPL; i++) ext[i] = part_reg[i];
    for (int i = WPL; i < 2 * WPL; i++) ext[i] = '0;
    total = p_reg;
    for (int l = FMA_COUNT - 1; l >= 0; l--) begin
      if (fma_valid_out[l]) begin
        ext[total] = fma_out[l*WORD_WIDTH +: WORD_WIDTH];
        total      = total + PW'(1);
      end
    end
    flush_eff = flush_in || (state_reg == FLUSH_PENDING);
    spill     = (total >= PW'(WPL));
    push_req  = spill || (flush_eff && (total != '0));
    push_line = '0;
    push_mask = '0;
    for (int i = 0; i < WPL; i++) begin
      push_line[(WPL-1-i)*WORD_WIDTH +: WORD_WIDTH] = ext[i];
      push_mask[WPL-1-i] = spill || (PW'(i) < total);
    end
    if (spill) begin
      p_next = total - PW'(WPL);
      for (int i = 0; i < WPL; i++) part_next[i] = ext[WPL+i];
    end else if (flush_eff) begin
      p_next = '0;
      for (int i = 0; i < WPL; i++) part_next[i] = '0;
    end else begin
      p_next = total;
      for (int i = 0; i < WPL; i++) part_next[i] = ext[i];
    end
    state_next = (flush_eff && spill) ? FLUSH_PENDING : FILLING;
  end

  logic [LW-1:0]  fifo_line [FIFO_DEPTH];
  logic [WPL-1:0] fifo_mask [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           overflow_reg;
  logic           pop, full, push_ok, drop;

  assign pop     = (count_reg != '0) && line_ready_in;
  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      fifo_line[wr_ptr_reg] <= push_line;
      fifo_mask[wr_ptr_reg] <= push_mask;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg    <= FILLING;
      p_reg        <= '0;
      for (int i = 0; i < WPL; i++) part_reg[i] <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      for (int i = 0; i < WPL; i++) part_reg[i] <= part_next[i];
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push_ok && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push_ok) count_reg <= count_reg - CW'(1);
      if (drop) overflow_reg <= 1'b1;
    end
  end

`ifdef FMA_LINE_PACKER_STATS_EN
  logic [15:0] pushed_reg, dropped_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pushed_reg  <= '0;
      dropped_reg <= '0;
    end else begin
      if (push_ok && pushed_reg != 16'hFFFF)  pushed_reg  <= pushed_reg + 16'd1;
      if (drop && dropped_reg != 16'hFFFF)    dropped_reg <= dropped_reg + 16'd1;
    end
  end

  assign lines_pushed_out  = pushed_reg;
  assign lines_dropped_out = dropped_reg;
`endif

  assign line_valid_out = (count_reg != '0);
  assign line_out       = line_valid_out ? fifo_line[rd_ptr_reg] : '0;
  assign line_mask_out  = line_valid_out ? fifo_mask[rd_ptr_reg] : '0;
  assign overflow_out   = overflow_reg;

endmodule
